// File: rtl/hamming_code_7_4_encoder.sv
// Streaming Hamming(7,4) encoder: one byte in, two 7-bit codewords out (data in cw[6:3], parity in cw[2:0]).
// Optional single-bit error injection on the first codeword and a wrapping count of accepted codewords.
module hamming_code_7_4_encoder #(
    parameter int unsigned HI_FIRST = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             inj_en,
    input  logic [2:0]       inj_pos,
    output logic [6:0]       out_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cw_count
);

    localparam int unsigned CW_W = 7;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SEND_FIRST  = 2'd1;
    localparam logic [1:0] SEND_SECOND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW_W-1:0]  out_cw_q, out_cw_d;
    logic             out_valid_q, out_valid_d;
    logic [CW_W-1:0]  second_q, second_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CW_W-1:0]  inj_mask_c;
    logic [CW_W-1:0]  first_cw_c;
    logic [CW_W-1:0]  second_cw_c;
    logic             accept_c;
    logic             out_hs_c;

    function automatic logic [CW_W-1:0] encode(input logic [3:0] d);
        return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
    endfunction

    // Position 7 is the "no flip" code, so it yields an empty mask.
    assign inj_mask_c  = (inj_en && (inj_pos != 3'd7)) ? CW_W'(7'd1 << inj_pos) : '0;
    assign first_cw_c  = (HI_FIRST != 0) ? (encode(in_data[7:4]) ^ inj_mask_c)
                                         : (encode(in_data[3:0]) ^ inj_mask_c);
    assign second_cw_c = (HI_FIRST != 0) ? encode(in_data[3:0]) : encode(in_data[7:4]);

    // Accepting in SEND_SECOND only when the second codeword leaves this cycle gives zero-bubble streaming.
    assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == SEND_SECOND) && out_ready));
    assign accept_c = in_valid && in_ready;
    assign out_hs_c = out_valid_q && out_ready;

    assign out_cw    = out_cw_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign cw_count  = cnt_q;

    always_comb begin
        state_d     = state_q;
        out_cw_d    = out_cw_q;
        out_valid_d = out_valid_q;
        second_d    = second_q;
        cnt_d       = out_hs_c ? (cnt_q + CNT_W'(1)) : cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    out_cw_d    = first_cw_c;
                    second_d    = second_cw_c;
                    out_valid_d = 1'b1;
                    state_d     = SEND_FIRST;
                end
            end
            SEND_FIRST: begin
                if (out_ready) begin
                    out_cw_d = second_q;
                    state_d  = SEND_SECOND;
                end
            end
            SEND_SECOND: begin
                if (out_ready) begin
                    if (accept_c) begin
                        out_cw_d = first_cw_c;
                        second_d = second_cw_c;
                        state_d  = SEND_FIRST;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_cw_q    <= '0;
            out_valid_q <= 1'b0;
            second_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_cw_q    <= out_cw_d;
            out_valid_q <= out_valid_d;
            second_q    <= second_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hamming_code_7_4_encoder.sv
// Bench for hamming_code_7_4_encoder: three instances (high-first, low-first, 4-bit counter) share stimulus
// and are compared every cycle against a queue-based codeword model, plus fixed vectors and corner sequences.
module tb_hamming_code_7_4_encoder;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] in_data;
    logic in_valid, inj_en, out_ready;
    logic [2:0] inj_pos;

    logic [6:0] cw_a, cw_b, cw_c;
    logic v_a, v_b, v_c, ir_a, ir_b, ir_c, busy_a, busy_b, busy_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0] cnt_c;

    int errors = 0;
    int checks = 0;

    logic [6:0] q_hi[$];
    logic [6:0] q_lo[$];
    int unsigned model_cnt;
    logic ir_seen;

    always #5 clk = ~clk;

    hamming_code_7_4_encoder #(.HI_FIRST(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_a),
        .inj_en(inj_en), .inj_pos(inj_pos), .out_cw(cw_a), .out_valid(v_a), .out_ready(out_ready),
        .busy(busy_a), .cw_count(cnt_a));

    hamming_code_7_4_encoder #(.HI_FIRST(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_b),
        .inj_en(inj_en), .inj_pos(inj_pos), .out_cw(cw_b), .out_valid(v_b), .out_ready(out_ready),
        .busy(busy_b), .cw_count(cnt_b));

    hamming_code_7_4_encoder #(.HI_FIRST(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_c),
        .inj_en(inj_en), .inj_pos(inj_pos), .out_cw(cw_c), .out_valid(v_c), .out_ready(out_ready),
        .busy(busy_c), .cw_count(cnt_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity bit = even parity over the data bits it covers.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        int p2, p1, p0;
        p2 = $countones(d & 4'b1110) % 2;
        p1 = $countones(d & 4'b1101) % 2;
        p0 = $countones(d & 4'b1011) % 2;
        return {d, p2[0], p1[0], p0[0]};
    endfunction

    function automatic logic [6:0] ref_mask(input logic en, input logic [2:0] pos);
        logic [6:0] m;
        m = '0;
        if (en && pos <= 3'd6) m[pos] = 1'b1;
        return m;
    endfunction

    task automatic check_outputs();
        int n;
        n = q_hi.size();
        chk("out_valid_a", {31'd0, v_a}, {31'd0, n > 0});
        chk("out_valid_b", {31'd0, v_b}, {31'd0, n > 0});
        chk("out_valid_c", {31'd0, v_c}, {31'd0, n > 0});
        chk("busy_a", {31'd0, busy_a}, {31'd0, n > 0});
        if (n > 0) begin
            chk("out_cw_a", {25'd0, cw_a}, {25'd0, q_hi[0]});
            chk("out_cw_b", {25'd0, cw_b}, {25'd0, q_lo[0]});
            chk("out_cw_c", {25'd0, cw_c}, {25'd0, q_hi[0]});
        end
        chk("cw_count_a", {16'd0, cnt_a}, model_cnt % 65536);
        chk("cw_count_c", {28'd0, cnt_c}, model_cnt % 16);
    endtask

    // One clock: drive inputs, check in_ready, advance model at the edge, check outputs after it.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic ie, input logic [2:0] ip,
                         input logic ordy);
        logic exp_ir, hs, acc;
        in_valid = iv; in_data = d; inj_en = ie; inj_pos = ip; out_ready = ordy;
        #1;
        ir_seen = ir_a;
        exp_ir = (q_hi.size() == 0) || (q_hi.size() == 1 && ordy);
        chk("in_ready_a", {31'd0, ir_a}, {31'd0, exp_ir});
        chk("in_ready_b", {31'd0, ir_b}, {31'd0, exp_ir});
        chk("in_ready_c", {31'd0, ir_c}, {31'd0, exp_ir});
        @(posedge clk);
        hs  = (q_hi.size() > 0) && ordy;
        acc = iv && exp_ir;
        if (hs) begin
            void'(q_hi.pop_front());
            void'(q_lo.pop_front());
            model_cnt++;
        end
        if (acc) begin
            q_hi.push_back(ref_enc(d[7:4]) ^ ref_mask(ie, ip));
            q_hi.push_back(ref_enc(d[3:0]));
            q_lo.push_back(ref_enc(d[3:0]) ^ ref_mask(ie, ip));
            q_lo.push_back(ref_enc(d[7:4]));
        end
        #1;
        check_outputs();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ie;
        logic [2:0] ip;
        logic [6:0] a1, a2, b1, b2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 3'd0, 7'h52, 7'h2D, 7'h2D, 7'h52};
        vecs[1] = '{8'hA5, 1'b1, 3'd6, 7'h12, 7'h2D, 7'h6D, 7'h52};
        vecs[2] = '{8'hA5, 1'b1, 3'd7, 7'h52, 7'h2D, 7'h2D, 7'h52};
        vecs[3] = '{8'h0F, 1'b0, 3'd0, 7'h00, 7'h7F, 7'h7F, 7'h00};
        vecs[4] = '{8'hF0, 1'b1, 3'd0, 7'h7E, 7'h00, 7'h01, 7'h7F};
        vecs[5] = '{8'h33, 1'b0, 3'd0, 7'h1E, 7'h1E, 7'h1E, 7'h1E};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b0;
        model_cnt = 0;
        #3;
        chk("reset_in_ready", {31'd0, ir_a}, 32'd0);
        chk("reset_out_valid", {31'd0, v_a}, 32'd0);
        chk("reset_out_cw", {25'd0, cw_a}, 32'd0);
        chk("reset_cw_count", {16'd0, cnt_a}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed vectors, out_ready high
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].data, vecs[i].ie, vecs[i].ip, 1'b1);
            chk("vec_first_a", {25'd0, cw_a}, {25'd0, vecs[i].a1});
            chk("vec_first_b", {25'd0, cw_b}, {25'd0, vecs[i].b1});
            chk("vec_busy1", {31'd0, busy_a}, 32'd1);
            cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
            chk("vec_second_a", {25'd0, cw_a}, {25'd0, vecs[i].a2});
            chk("vec_second_b", {25'd0, cw_b}, {25'd0, vecs[i].b2});
            chk("vec_busy2", {31'd0, busy_a}, 32'd1);
            cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
            chk("vec_idle", {31'd0, v_a}, 32'd0);
        end
        chk("vec_count", {16'd0, cnt_a}, 32'd12);

        // Back-to-back 0x0F then 0xF0
        cycle(1'b1, 8'h0F, 1'b0, 3'd0, 1'b1);
        chk("b2b_cw0", {25'd0, cw_a}, 32'h00);
        cycle(1'b1, 8'hF0, 1'b0, 3'd0, 1'b1);
        chk("b2b_cw1", {25'd0, cw_a}, 32'h7F);
        cycle(1'b1, 8'hF0, 1'b0, 3'd0, 1'b1);
        chk("b2b_in_ready_send_second", {31'd0, ir_seen}, 32'd1);
        chk("b2b_cw2", {25'd0, cw_a}, 32'h7F);
        cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        chk("b2b_cw3", {25'd0, cw_a}, 32'h00);
        cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

        // Backpressure for five cycles
        cycle(1'b1, 8'hA5, 1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'h3C, 1'b0, 3'd0, 1'b0);
            chk("hold_cw", {25'd0, cw_a}, 32'h52);
            chk("hold_in_ready", {31'd0, ir_seen}, 32'd0);
        end
        cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        chk("release_cw", {25'd0, cw_a}, 32'h2D);
        cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        chk("release_idle", {31'd0, v_a}, 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

        // Async reset during SEND_FIRST
        cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 3'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, v_a}, 32'd0);
        chk("rst_mid_cw_count", {16'd0, cnt_a}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, ir_a}, 32'd0);
        q_hi.delete(); q_lo.delete(); model_cnt = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
            chk("rst_no_residual", {31'd0, v_a}, 32'd0);
        end

        // Sixteen codewords wrap the 4-bit counter
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'(k * 37), 1'b0, 3'd0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        chk("wrap_cnt_c", {28'd0, cnt_c}, 32'd0);
        chk("wrap_cnt_a", {16'd0, cnt_a}, 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_code_7_4_encoder.md
Name: hamming_code_7_4_encoder

Overview:
- Streaming Hamming(7,4) encoder. It accepts one 8-bit byte per input handshake and emits two 7-bit codewords per byte on an output valid/ready handshake.
- Codeword bit ordering matches the team's 7-bit corrector: cw[6:3] carry the data, cw[2:0] carry the parity.
- Sits on the transmit side of links protected by that corrector.
- Includes single-bit error injection so the corrector can be exercised end to end, plus a running codeword counter.

Parameters:
- HI_FIRST, 1, 1 = high nibble encoded/emitted first; 0 = low nibble first.
- CNT_W, 16, width of the emitted-codeword counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  byte to encode.
- in_valid  in  1  in_data valid.
- in_ready  out  1  encoder can accept a byte this cycle.
- inj_en  in  1  request single-bit error on this byte's first codeword; sampled with the byte.
- inj_pos  in  3  bit index 0..6 to flip; 7 = no flip; sampled with the byte.
- out_cw  out  7  encoded codeword (registered).
- out_valid  out  1  out_cw valid.
- out_ready  in  1  downstream accepts out_cw.
- busy  out  1  high while a byte is being emitted (state != IDLE).
- cw_count  out  CNT_W  number of codewords accepted downstream.

Behaviour:
- Encoding for nibble d[3:0]:
  - cw[6:3] = d[3:0].
  - cw[2] = d3^d2^d1.
  - cw[1] = d3^d2^d0.
  - cw[0] = d3^d1^d0.
- Reset (async assert, rst_n low): state=IDLE; out_cw=0; out_valid=0; cw_count=0; byte and injection registers cleared.
  - in_ready=0 while rst_n low.
  - Reset mid-byte discards the pending codewords; nothing is emitted after release until a new byte is accepted.
- Input handshake: a byte is accepted when in_valid && in_ready at the clock edge. The handshake is defined at the edge, so the encoder must not depend on in_valid staying high.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept, register both codewords and the injection request; out_cw = first codeword (injection applied); go to SEND_FIRST.
  - SEND_FIRST: out_valid=1, in_ready=0. Hold out_cw stable until out_ready. On out_ready: out_cw = second codeword (never injected); go to SEND_SECOND.
  - SEND_SECOND: out_valid=1. in_ready = out_ready (combinational).
    - out_ready && in_valid: accept the new byte, load its first codeword, go to SEND_FIRST. This gives zero-bubble back-to-back operation at one codeword per cycle.
    - out_ready && !in_valid: out_valid=0, go to IDLE.
    - !out_ready: hold.
- Injection: when inj_en=1 and inj_pos<=6 at byte acceptance, out_cw of the first codeword = encoded ^ (1<<inj_pos). inj_pos=7 or inj_en=0 means no flip.
- Output stability: out_cw and out_valid change only on an output handshake, an input accept in IDLE, or reset.
- cw_count increments by 1 on each out_valid && out_ready cycle and wraps modulo 2^CNT_W (all-ones -> 0).
- Latency: byte accepted in cycle N -> first codeword valid in cycle N+1 -> second codeword valid one cycle after the first handshake.
- Sustained throughput: 2 cycles per byte with out_ready tied high.

Test Plan:
- Reset then byte 0xA5, HI_FIRST=1, out_ready=1 -> out_cw 0x52 at N+1, 0x2D at N+2; busy high for 2 cycles; cw_count=2.
- Bytes 0x0F then 0xF0 back-to-back, out_ready=1:
  - Required codewords: 0x00, 0x7F, 0x7F, 0x00 on consecutive cycles.
  - in_ready high during SEND_SECOND; no idle cycle between bytes.
- Byte 0xA5 with out_ready held low 5 cycles:
  - out_cw holds 0x52 and in_ready stays 0 throughout.
  - Release -> 0x2D, then IDLE.
- Byte 0xA5, inj_en=1, inj_pos=6 -> 0x12 then 0x2D (second unflipped). Repeat with inj_pos=7 -> 0x52, 0x2D.
- HI_FIRST=0, byte 0xA5 -> 0x2D then 0x52.
- rst_n pulsed low during SEND_FIRST -> out_valid=0, cw_count=0 immediately; no residual codeword after release.
- CNT_W=4: emit 16 codewords -> cw_count wraps to 0.
